// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store sequencer that sits between the EX/MEM pipeline register and the
// block RAM wrapper of the data memory. One request is taken at a time and the
// unit keeps the pipeline stalled (busy) until that request has produced its
// single response pulse.
//
// Address decode at acceptance:
//   MEM      : addr[31:ADDR_BITS] == 0  -> data memory (one-cycle strobe,
//              then READ_LATENCY cycles of wait for loads)
//   IO       : addr == IO_ADDR          -> byte-wide valid/ready I/O port
//   UNMAPPED : anything else            -> loads return 0, stores are dropped
// Requests with both or neither of req_read/req_write are NOPs: they complete
// immediately with resp_rdata = 0 and touch nothing else.
//
// Ports:
//   CLK, reset          clock (rising edge), asynchronous active-low reset
//   req_*               request handshake and fields from the pipeline
//   resp_valid/rdata    one-cycle completion pulse and load result
//   busy                pipeline stall, high whenever the unit is not idle
//   mem_*               enable-style controls and data of the data memory
//   io_tx_*             I/O write handshake (byte out)
//   io_rx_*             I/O read handshake (byte in)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_BITS    = 17,
  parameter logic [31:0] IO_ADDR      = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        reset,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,

  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy,

  output logic        mem_distinct,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_read_data,

  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  output logic [7:0]  io_tx_data,

  output logic        io_rx_ready,
  input  logic        io_rx_valid,
  input  logic [7:0]  io_rx_data
);

  // READ_LATENCY is limited to 1..4, so the wait counter never needs more
  // than two bits.
  localparam int unsigned         CNT_W     = 2;
  localparam logic [CNT_W-1:0]    WAIT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_IO_TX,
    S_IO_RX,
    S_RESP
  } state_t;

  state_t             r_state;
  logic               r_isRead;
  logic [CNT_W-1:0]   r_waitCnt;

  logic               r_reqReady;
  logic               r_busy;
  logic               r_respValid;
  logic [31:0]        r_respRdata;
  logic               r_memDistinct;
  logic [31:0]        r_memAddress;
  logic [31:0]        r_memWriteData;
  logic               r_memWrite;
  logic               r_memRead;
  logic               r_ioTxValid;
  logic [7:0]         r_ioTxData;
  logic               r_ioRxReady;

  logic               w_isMem;
  logic               w_isIo;
  logic               w_opRead;
  logic               w_opWrite;

  // Decode of the live request inputs; only consumed on the accepting edge,
  // after which everything needed is held in registers.
  assign w_isMem   = (req_addr[31:ADDR_BITS] == '0);
  assign w_isIo    = (req_addr == IO_ADDR);
  assign w_opRead  = req_read & ~req_write;
  assign w_opWrite = req_write & ~req_read;

  // Sequencer. Every output is a register that is set on the edge entering
  // the state it belongs to, so outputs change cleanly with the state.
  // The memory strobes and resp_valid default to 0 each cycle because they
  // must only ever last a single cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_isRead       <= 1'b0;
      r_waitCnt      <= '0;
      r_reqReady     <= 1'b1;
      r_busy         <= 1'b0;
      r_respValid    <= 1'b0;
      r_respRdata    <= '0;
      r_memDistinct  <= 1'b0;
      r_memAddress   <= '0;
      r_memWriteData <= '0;
      r_memWrite     <= 1'b0;
      r_memRead      <= 1'b0;
      r_ioTxValid    <= 1'b0;
      r_ioTxData     <= '0;
      r_ioRxReady    <= 1'b0;
    end else begin
      r_respValid   <= 1'b0;
      r_memDistinct <= 1'b0;
      r_memWrite    <= 1'b0;
      r_memRead     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_reqReady <= 1'b0;
            r_busy     <= 1'b1;
            if (!w_opRead && !w_opWrite) begin
              // NOP: no side effects, result forced to zero.
              r_respRdata <= '0;
              r_respValid <= 1'b1;
              r_state     <= S_RESP;
            end else if (w_isMem) begin
              // Address and data are only loaded here so they keep showing
              // the last memory access while the unit does anything else.
              r_memAddress   <= req_addr;
              r_memWriteData <= req_wdata;
              r_memDistinct  <= 1'b1;
              r_memRead      <= w_opRead;
              r_memWrite     <= w_opWrite;
              r_isRead       <= w_opRead;
              r_state        <= S_ISSUE;
            end else if (w_isIo && w_opWrite) begin
              r_ioTxValid <= 1'b1;
              r_ioTxData  <= req_wdata[7:0];
              r_state     <= S_IO_TX;
            end else if (w_isIo) begin
              r_ioRxReady <= 1'b1;
              r_state     <= S_IO_RX;
            end else begin
              // Unmapped: loads read as zero, stores vanish.
              if (w_opRead) begin
                r_respRdata <= '0;
              end
              r_respValid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end

        S_ISSUE: begin
          if (r_isRead) begin
            r_waitCnt <= WAIT_LOAD;
            r_state   <= S_WAIT;
          end else begin
            r_respValid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        // The RAM data becomes valid in the WAIT cycle where the counter
        // has run down to zero; capture it on that cycle's edge.
        S_WAIT: begin
          if (r_waitCnt == '0) begin
            r_respRdata <= mem_read_data;
            r_respValid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_waitCnt <= r_waitCnt - 1'b1;
          end
        end

        S_IO_TX: begin
          if (io_tx_ready) begin
            r_ioTxValid <= 1'b0;
            r_respValid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_IO_RX: begin
          if (io_rx_valid) begin
            r_ioRxReady <= 1'b0;
            r_respRdata <= {24'h0, io_rx_data};
            r_respValid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          r_reqReady <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_ioTxValid <= 1'b0;
          r_ioRxReady <= 1'b0;
          r_reqReady  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = r_reqReady;
  assign busy           = r_busy;
  assign resp_valid     = r_respValid;
  assign resp_rdata     = r_respRdata;
  assign mem_distinct   = r_memDistinct;
  assign mem_address    = r_memAddress;
  assign mem_write_data = r_memWriteData;
  assign mem_MemWrite   = r_memWrite;
  assign mem_MemRead    = r_memRead;
  assign io_tx_valid    = r_ioTxValid;
  assign io_tx_data     = r_ioTxData;
  assign io_rx_ready    = r_ioRxReady;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Two instances of the unit: dut1 with READ_LATENCY=1 and dut3 with
// READ_LATENCY=3, each behind a small RAM model with the matching latency.
// Stimulus tasks push the hand-computed response (data and cycle) into a
// per-instance queue; separate monitors pop and compare on every resp_valid.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic CLK   = 1'b0;
  logic reset = 1'b0;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Request fields and I/O inputs are shared; each instance has its own valid.
  logic        req_read    = 1'b0;
  logic        req_write   = 1'b0;
  logic [31:0] req_addr    = '0;
  logic [31:0] req_wdata   = '0;
  logic        io_tx_ready = 1'b0;
  logic        io_rx_valid = 1'b0;
  logic [7:0]  io_rx_data  = '0;

  logic        reqValid1 = 1'b0, reqValid3 = 1'b0;
  logic        reqReady1, reqReady3;
  logic        respValid1, respValid3;
  logic [31:0] respRdata1, respRdata3;
  logic        busy1, busy3;
  logic        memDistinct1, memDistinct3;
  logic [31:0] memAddress1, memAddress3;
  logic [31:0] memWriteData1, memWriteData3;
  logic        memWrite1, memWrite3;
  logic        memRead1, memRead3;
  logic [31:0] memReadData1, memReadData3;
  logic        ioTxValid1, ioTxValid3;
  logic [7:0]  ioTxData1, ioTxData3;
  logic        ioRxReady1, ioRxReady3;

  mem_access_unit #(.READ_LATENCY(1)) dut1 (
    .CLK(CLK), .reset(reset),
    .req_valid(reqValid1), .req_ready(reqReady1), .req_read(req_read),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(respValid1), .resp_rdata(respRdata1), .busy(busy1),
    .mem_distinct(memDistinct1), .mem_address(memAddress1),
    .mem_write_data(memWriteData1), .mem_MemWrite(memWrite1),
    .mem_MemRead(memRead1), .mem_read_data(memReadData1),
    .io_tx_valid(ioTxValid1), .io_tx_ready(io_tx_ready), .io_tx_data(ioTxData1),
    .io_rx_ready(ioRxReady1), .io_rx_valid(io_rx_valid), .io_rx_data(io_rx_data)
  );

  mem_access_unit #(.READ_LATENCY(3)) dut3 (
    .CLK(CLK), .reset(reset),
    .req_valid(reqValid3), .req_ready(reqReady3), .req_read(req_read),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(respValid3), .resp_rdata(respRdata3), .busy(busy3),
    .mem_distinct(memDistinct3), .mem_address(memAddress3),
    .mem_write_data(memWriteData3), .mem_MemWrite(memWrite3),
    .mem_MemRead(memRead3), .mem_read_data(memReadData3),
    .io_tx_valid(ioTxValid3), .io_tx_ready(io_tx_ready), .io_tx_data(ioTxData3),
    .io_rx_ready(ioRxReady3), .io_rx_valid(io_rx_valid), .io_rx_data(io_rx_data)
  );

  // RAM models indexed by the low address byte; the read path returns a
  // poison word unless a read strobe was seen at the right edge.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1 = '0, p0 = '0, p1 = '0, p2 = '0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h1111_0000 | 32'(i);
      mem3[i] = 32'hC0DE_0000 | 32'(i);
    end
  end

  always @(posedge CLK) begin
    if (memWrite1) mem1[memAddress1[7:0]] <= memWriteData1;
    rd1 <= memRead1 ? mem1[memAddress1[7:0]] : 32'hBAD0_BAD1;
  end
  assign memReadData1 = rd1;

  always @(posedge CLK) begin
    if (memWrite3) mem3[memAddress3[7:0]] <= memWriteData3;
    p0 <= memRead3 ? mem3[memAddress3[7:0]] : 32'hBAD0_BAD3;
    p1 <= p0;
    p2 <= p1;
  end
  assign memReadData3 = p2;

  typedef struct packed {
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
    end
  endtask

  // Monitors: every response must match the oldest expectation in both data
  // and arrival cycle; a response with nothing queued is an error.
  always @(negedge CLK) begin : mon1
    exp_t e;
    if (reset && respValid1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1 unexpected resp", 32'(respValid1), 32'd0);
      end else begin
        e = q1.pop_front();
        checkOutput("dut1 resp_rdata", respRdata1, e.rdata);
        checkOutput("dut1 resp cycle", 32'(cyc), 32'(e.cycle));
      end
    end
  end

  always @(negedge CLK) begin : mon3
    exp_t e;
    if (reset && respValid3) begin
      if (q3.size() == 0) begin
        checkOutput("dut3 unexpected resp", 32'(respValid3), 32'd0);
      end else begin
        e = q3.pop_front();
        checkOutput("dut3 resp_rdata", respRdata3, e.rdata);
        checkOutput("dut3 resp cycle", 32'(cyc), 32'(e.cycle));
      end
    end
  end

  // Issues one request to dut1 (sel=0) or dut3 (sel=1). Returns #1 after the
  // accepting edge, i.e. inside cycle A+1, with the request inputs already
  // scrambled so later sampling of them would be visible.
  task automatic applyStimulus(input bit sel, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int lat, input logic [31:0] expRdata,
                               input bit expectResp);
    int t;
    exp_t e;
    t = 0;
    @(negedge CLK);
    while (!(sel ? reqReady3 : reqReady1) && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) checkOutput("req_ready timeout", 32'd0, 32'd1);
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    if (sel) reqValid3 = 1'b1; else reqValid1 = 1'b1;
    if (expectResp) begin
      e.rdata = expRdata;
      e.cycle = cyc + lat;
      if (sel) q3.push_back(e); else q1.push_back(e);
    end
    @(posedge CLK);
    #1;
    reqValid1 = 1'b0;
    reqValid3 = 1'b0;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h1234_5678;
    req_read  = ~rd;
    req_write = ~wr;
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((q1.size() != 0 || q3.size() != 0) && t < 40) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 40) begin
      checkOutput("response timeout", 32'(q1.size() + q3.size()), 32'd0);
      q1.delete();
      q3.delete();
    end
    @(negedge CLK);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    // Reset state while reset is held low.
    repeat (2) @(negedge CLK);
    checkOutput("rst req_ready", 32'(reqReady1), 32'd1);
    checkOutput("rst busy", 32'(busy1), 32'd0);
    checkOutput("rst strobes", 32'({memDistinct1, memRead1, memWrite1}), 32'd0);
    checkOutput("rst resp", 32'({respValid1, ioTxValid1, ioRxReady1}), 32'd0);
    checkOutput("rst rdata", respRdata1, 32'd0);
    checkOutput("rst dut3 req_ready", 32'(reqReady3), 32'd1);
    reset = 1'b1;
    @(negedge CLK);

    // Reset during ISSUE: strobes must vanish without waiting for an edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h0, 1'b0);
    checkOutput("issue MemRead", 32'(memRead1), 32'd1);
    checkOutput("issue distinct", 32'(memDistinct1), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst-issue strobes", 32'({memDistinct1, memRead1}), 32'd0);
    checkOutput("rst-issue busy", 32'(busy1), 32'd0);
    checkOutput("rst-issue req_ready", 32'(reqReady1), 32'd1);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);

    // Reset during WAIT on the latency-3 unit: no response may follow.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h0, 1'b0);
    @(posedge CLK);
    #1;
    checkOutput("wait busy", 32'(busy3), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst-wait busy", 32'(busy3), 32'd0);
    checkOutput("rst-wait req_ready", 32'(reqReady3), 32'd1);
    @(negedge CLK);
    reset = 1'b1;
    repeat (6) @(negedge CLK);

    // Store: strobe in A+1, response in A+2, rdata untouched (0 after reset).
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b1);
    checkOutput("st MemWrite/Read", 32'({memWrite1, memRead1}), 32'b10);
    checkOutput("st distinct", 32'(memDistinct1), 32'd1);
    checkOutput("st address", memAddress1, 32'h10);
    checkOutput("st wdata", memWriteData1, 32'hDEADBEEF);
    @(posedge CLK);
    #1;
    checkOutput("st strobe one cycle", 32'({memWrite1, memDistinct1}), 32'd0);
    checkOutput("st address held", memAddress1, 32'h10);
    checkOutput("st req_ready in RESP", 32'(reqReady1), 32'd0);
    waitDrain();

    // Load back, latency 1: response in B+3.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b1);
    checkOutput("ld MemRead/Write", 32'({memRead1, memWrite1}), 32'b10);
    checkOutput("ld address ignores input change", memAddress1, 32'h10);
    waitDrain();

    // Top word of memory on latency 3: response in A+5.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0001_FFFF, 32'h0, 5, 32'hC0DE_00FF, 1'b1);
    checkOutput("ld3 MemRead", 32'(memRead3), 32'd1);
    checkOutput("ld3 address", memAddress3, 32'h0001_FFFF);
    waitDrain();

    // First address past memory: unmapped load returns 0, no strobes.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0002_0000, 32'h0, 1, 32'h0, 1'b1);
    checkOutput("unmapped strobes", 32'({memDistinct3, memRead3, memWrite3}), 32'd0);
    checkOutput("unmapped busy", 32'(busy3), 32'd1);
    waitDrain();

    // Unmapped store: dropped, rdata keeps the last load value.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_0004, 32'h55AA55AA, 1, 32'hDEADBEEF, 1'b1);
    checkOutput("unmapped st strobes", 32'({memDistinct1, memWrite1, ioTxValid1}), 32'd0);
    waitDrain();

    // I/O write with io_tx_ready low for 4 cycles: valid for 5, resp A+6.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 32'h1234_56A5, 6, 32'hDEADBEEF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("io_tx_valid", 32'(ioTxValid1), 32'd1);
      checkOutput("io_tx_data", 32'(ioTxData1), 32'hA5);
      checkOutput("io tx busy", 32'(busy1), 32'd1);
      if (k == 4) io_tx_ready = 1'b1;
      @(posedge CLK);
      #1;
    end
    io_tx_ready = 1'b0;
    checkOutput("io_tx_valid drop", 32'(ioTxValid1), 32'd0);
    waitDrain();

    // I/O read with the byte arriving in the third IO_RX cycle: resp A+4.
    io_rx_data = 8'h5C;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 4, 32'h0000_005C, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("io_rx_ready", 32'(ioRxReady1), 32'd1);
      if (k == 2) io_rx_valid = 1'b1;
      @(posedge CLK);
      #1;
    end
    io_rx_valid = 1'b0;
    checkOutput("io_rx_ready drop", 32'(ioRxReady1), 32'd0);
    waitDrain();

    // NOP with both read and write: A+1, rdata 0, no strobes, address held.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF, 1, 32'h0, 1'b1);
    checkOutput("nop strobes", 32'({memDistinct1, memRead1, memWrite1}), 32'd0);
    checkOutput("nop address held", memAddress1, 32'h10);
    waitDrain();

    // Reload a nonzero value, then a NOP with neither op must clear it.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1);
    checkOutput("nop0 strobes", 32'({memDistinct1, memRead1, memWrite1}), 32'd0);
    waitDrain();
    checkOutput("idle req_ready", 32'(reqReady1), 32'd1);
    checkOutput("idle busy", 32'(busy1), 32'd0);

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
